// File: rtl/game_input_ctrl.sv
// Button front-end for the board game datapath: synchronise, debounce and edge-detect
// three keys, then sequence put -> wait -> turn with validation of the target cell.
module game_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clock,
  input  logic resetn,
  input  logic key_put,
  input  logic key_right,
  input  logic key_down,
  input  logic cell_empty,
  input  logic game_over,
  output logic put,
  output logic right,
  output logic down,
  output logic turn_control,
  output logic reject,
  output logic busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PUT  = 2'd1,
    WAIT = 2'd2,
    TURN = 2'd3
  } state_t;

  // Bit order across the per-key vectors: [0]=put, [1]=right, [2]=down.
  logic [2:0]       keys;
  logic [2:0]       sync1;
  logic [2:0]       sync2;
  logic [2:0]       db;
  logic [2:0]       db_d;
  logic [2:0]       ev;
  logic [CNT_W-1:0] cnt [3];
  state_t           state;

  assign keys = {key_down, key_right, key_put};

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= keys;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      db   <= '1;
      db_d <= '1;
      for (int unsigned i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      db_d <= db;
      for (int unsigned i = 0; i < 3; i++) begin
        if (sync2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          db[i]  <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Press event is the cycle right after the debounced level falls; releases are ignored.
  always_comb begin
    ev = db_d & ~db;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      put          <= 1'b0;
      right        <= 1'b0;
      down         <= 1'b0;
      turn_control <= 1'b0;
      reject       <= 1'b0;
      busy         <= 1'b0;
    end else begin
      put          <= 1'b0;
      right        <= 1'b0;
      down         <= 1'b0;
      turn_control <= 1'b0;
      reject       <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (ev[0]) begin
            if (cell_empty && !game_over) begin
              state <= PUT;
              put   <= 1'b1;
              busy  <= 1'b1;
            end else begin
              reject <= 1'b1;
            end
          end else if (ev[1]) begin
            right <= 1'b1;
          end else if (ev[2]) begin
            down <= 1'b1;
          end
        end
        PUT: begin
          state <= WAIT;
          busy  <= 1'b1;
        end
        WAIT: begin
          state        <= TURN;
          turn_control <= 1'b1;
          busy         <= 1'b1;
        end
        TURN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_input_ctrl.sv
// Scoreboard bench for game_input_ctrl with a short debounce window; every strobe the
// DUT emits is matched against a queue of expected (cycle, strobe) entries.
module tb_game_input_ctrl;

  localparam int D = 4;
  localparam int LAT = 2 + D + 1;

  localparam logic [4:0] E_PUT   = 5'b10000;
  localparam logic [4:0] E_RIGHT = 5'b01000;
  localparam logic [4:0] E_DOWN  = 5'b00100;
  localparam logic [4:0] E_TURN  = 5'b00010;
  localparam logic [4:0] E_REJ   = 5'b00001;

  typedef struct {
    int unsigned cyc;
    logic [4:0]  vec;
  } exp_t;

  logic clock = 1'b0;
  logic resetn;
  logic key_put, key_right, key_down;
  logic cell_empty, game_over;
  logic put, right, down, turn_control, reject, busy;

  int unsigned cyc = 0;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned bs = 1;
  int unsigned be = 0;
  exp_t        sb [$];

  game_input_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .key_put      (key_put),
    .key_right    (key_right),
    .key_down     (key_down),
    .cell_empty   (cell_empty),
    .game_over    (game_over),
    .put          (put),
    .right        (right),
    .down         (down),
    .turn_control (turn_control),
    .reject       (reject),
    .busy         (busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic push_exp(input int unsigned c, input logic [4:0] v);
    exp_t e;
    e.cyc = c;
    e.vec = v;
    sb.push_back(e);
  endtask

  // Key driven low at cycle c: put strobe at c+LAT, turn two cycles later, busy in between.
  task automatic push_put(input int unsigned c);
    push_exp(c + LAT, E_PUT);
    push_exp(c + LAT + 2, E_TURN);
    bs = c + LAT;
    be = c + LAT + 2;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  always @(negedge clock) begin
    logic [4:0] vec;
    exp_t e;
    vec = {put, right, down, turn_control, reject};
    chk("busy", {31'd0, busy}, {31'd0, (cyc >= bs) && (cyc <= be)});
    if (vec !== 5'b0) begin
      if (sb.size() == 0) begin
        chk("unexpected_strobe", {27'd0, vec}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("strobe_cycle", cyc, e.cyc);
        chk("strobe_kind", {27'd0, vec}, {27'd0, e.vec});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c;
    resetn = 1'b0;
    key_put = 1'b1;
    key_right = 1'b1;
    key_down = 1'b1;
    cell_empty = 1'b0;
    game_over = 1'b0;

    wait_cyc(3);
    chk("reset_outputs", {26'd0, put, right, down, turn_control, reject, busy}, 32'd0);
    resetn = 1'b1;
    wait_cyc(100);

    // Bounce bursts shorter than the window, then one stable press held long.
    repeat (5) begin
      key_right = 1'b0;
      wait_cyc(3);
      key_right = 1'b1;
      wait_cyc(1);
    end
    key_right = 1'b0;
    push_exp(cyc + LAT, E_RIGHT);
    wait_cyc(60);
    key_right = 1'b1;
    wait_cyc(15);

    cell_empty = 1'b1;
    key_put = 1'b0;
    push_put(cyc);
    wait_cyc(20);
    key_put = 1'b1;
    wait_cyc(15);

    cell_empty = 1'b0;
    key_put = 1'b0;
    push_exp(cyc + LAT, E_REJ);
    wait_cyc(20);
    key_put = 1'b1;
    wait_cyc(15);

    cell_empty = 1'b1;
    game_over = 1'b1;
    key_put = 1'b0;
    push_exp(cyc + LAT, E_REJ);
    wait_cyc(20);
    key_put = 1'b1;
    wait_cyc(15);
    game_over = 1'b0;

    key_put = 1'b0;
    key_right = 1'b0;
    key_down = 1'b0;
    push_put(cyc);
    wait_cyc(20);
    key_put = 1'b1;
    key_right = 1'b1;
    key_down = 1'b1;
    wait_cyc(15);

    // Down press timed so its event lands while the FSM sits in WAIT.
    key_put = 1'b0;
    push_put(cyc);
    wait_cyc(2);
    key_down = 1'b0;
    wait_cyc(20);
    key_put = 1'b1;
    key_down = 1'b1;
    wait_cyc(15);

    c = cyc;
    key_put = 1'b0;
    push_exp(c + LAT, E_PUT);
    bs = c + LAT;
    be = c + LAT;
    wait_cyc(LAT);
    chk("mid_put_high", {31'd0, put}, 32'd1);
    #1;
    resetn = 1'b0;
    key_put = 1'b1;
    #1;
    chk("mid_reset_outputs", {26'd0, put, right, down, turn_control, reject, busy}, 32'd0);
    wait_cyc(3);
    resetn = 1'b1;
    wait_cyc(20);

    key_put = 1'b0;
    push_put(cyc);
    wait_cyc(20);
    key_put = 1'b1;
    wait_cyc(15);

    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
